// File: rtl/psg_pkg.sv
// Shared constants for the SN76489-style PSG: byte field positions,
// channel encoding, register addresses and the silent attenuation value.
package psg_pkg;

  // Command byte layout: [7] latch flag, [6:4] register address on latch bytes.
  localparam int LATCH_BIT = 7;
  localparam int REG_MSB   = 6;
  localparam int REG_LSB   = 4;

  // Low nibble of a tone register comes from the latch byte, the rest from data bytes.
  localparam int TONE_LO_BITS = 4;

  localparam int NOISE_CHANNEL = 3;

  typedef enum logic [1:0] {
    CH_TONE0 = 2'd0,
    CH_TONE1 = 2'd1,
    CH_TONE2 = 2'd2,
    CH_NOISE = 2'(NOISE_CHANNEL)
  } chan_e;

  // Register address {R2,R1,R0}: R2R1 = channel, R0 = 1 for attenuation.
  localparam logic [2:0] REG_NOISE = 3'b110;

  localparam logic [3:0] ATTN_SILENT = 4'hF;

  typedef struct packed {
    chan_e ch;
    logic  is_attn;
  } reg_addr_t;

  function automatic reg_addr_t decode_addr(input logic [2:0] addr);
    reg_addr_t r;
    r.ch      = chan_e'(addr[2:1]);
    r.is_attn = addr[0];
    return r;
  endfunction

endpackage

// File: rtl/psg_write_throttle.sv
// Write throttle: holds off host writes for WRITE_CYCLES cycles after each accept.
// Latency: ready/overrun registered (1 cycle); accept_o is wr_en_i & ready_o.
// Backpressure: writes sampled while busy are dropped and flagged on overrun_o.
module psg_write_throttle #(
  parameter int WRITE_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en_i,
  output logic ready_o,
  output logic overrun_o,
  output logic accept_o
);

  localparam int CW = (WRITE_CYCLES > 0) ? $clog2(WRITE_CYCLES + 1) : 1;

  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          overrun_q, overrun_d;

  assign accept_o  = wr_en_i & ready_q;
  assign ready_o   = ready_q;
  assign overrun_o = overrun_q;

  // Reload on accept, otherwise count down to idle; ready tracks the idle state.
  always_comb begin
    count_d = count_q;
    if (accept_o) begin
      count_d = CW'(WRITE_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
    ready_d   = (count_d == '0);
    overrun_d = wr_en_i & ~ready_q;
  end

  // Busy counter and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      ready_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: rtl/psg_register_interface.sv
// PSG host register interface: decodes latch/data bytes into attenuation, tone and noise registers.
// Latency: 1 cycle from accepted write to register/lfsr_reset update.
// Backpressure: ready drops for WRITE_CYCLES cycles after each accept; writes while busy are dropped.
module psg_register_interface
  import psg_pkg::*;
#(
  parameter int NUM_TONES                = 3,
  parameter int ATTENUATION_CONTROL_BITS = 4,
  parameter int FREQUENCY_COUNTER_BITS   = 10,
  parameter int NOISE_CONTROL_BITS       = 3,
  parameter int WRITE_CYCLES             = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [7:0]                                   data_in,
  input  logic                                         wr_en,
  output logic                                         ready,
  output logic                                         overrun,
  output logic [4*ATTENUATION_CONTROL_BITS-1:0]        attn_flat,
  output logic [NUM_TONES*FREQUENCY_COUNTER_BITS-1:0]  tone_freq_flat,
  output logic [NOISE_CONTROL_BITS-1:0]                noise_ctrl,
  output logic                                         lfsr_reset,
  output logic [2:0]                                   latched_reg
);

  localparam int ACB = ATTENUATION_CONTROL_BITS;
  localparam int FCB = FREQUENCY_COUNTER_BITS;
  localparam int NCB = NOISE_CONTROL_BITS;

  logic            accept;
  logic [ACB-1:0]  attn_q [4];
  logic [ACB-1:0]  attn_d [4];
  logic [FCB-1:0]  tone_q [NUM_TONES];
  logic [FCB-1:0]  tone_d [NUM_TONES];
  logic [NCB-1:0]  noise_q, noise_d;
  logic [2:0]      latched_q, latched_d;
  logic            lfsr_q, lfsr_d;
  logic            is_latch;
  logic [2:0]      reg_sel;
  reg_addr_t       addr;

  psg_write_throttle #(
    .WRITE_CYCLES(WRITE_CYCLES)
  ) u_throttle (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr_en),
    .ready_o  (ready),
    .overrun_o(overrun),
    .accept_o (accept)
  );

  // Decode the accepted byte: latch bytes carry their own address, data bytes reuse the latched one.
  always_comb begin
    is_latch  = data_in[LATCH_BIT];
    reg_sel   = is_latch ? data_in[REG_MSB:REG_LSB] : latched_q;
    addr      = decode_addr(reg_sel);
    attn_d    = attn_q;
    tone_d    = tone_q;
    noise_d   = noise_q;
    latched_d = latched_q;
    lfsr_d    = 1'b0;
    if (accept) begin
      if (is_latch) begin
        latched_d = reg_sel;
      end
      if (addr.is_attn) begin
        attn_d[addr.ch] = ACB'(data_in[3:0]);
      end else if (reg_sel == REG_NOISE) begin
        noise_d = data_in[NCB-1:0];
        lfsr_d  = 1'b1;
      end else begin
        for (int k = 0; k < NUM_TONES; k++) begin
          if (reg_sel[2:1] == 2'(k)) begin
            if (is_latch) begin
              tone_d[k][TONE_LO_BITS-1:0] = data_in[TONE_LO_BITS-1:0];
            end else begin
              tone_d[k][FCB-1:TONE_LO_BITS] = data_in[FCB-TONE_LO_BITS-1:0];
            end
          end
        end
      end
    end
  end

  // Register file; attenuation resets to silent so nothing sounds before the host programs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        attn_q[k] <= ACB'(ATTN_SILENT);
      end
      for (int k = 0; k < NUM_TONES; k++) begin
        tone_q[k] <= '0;
      end
      noise_q   <= '0;
      latched_q <= '0;
      lfsr_q    <= 1'b0;
    end else begin
      attn_q    <= attn_d;
      tone_q    <= tone_d;
      noise_q   <= noise_d;
      latched_q <= latched_d;
      lfsr_q    <= lfsr_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_attn_flat
    assign attn_flat[g*ACB +: ACB] = attn_q[g];
  end

  for (genvar g = 0; g < NUM_TONES; g++) begin : g_tone_flat
    assign tone_freq_flat[g*FCB +: FCB] = tone_q[g];
  end

  assign noise_ctrl  = noise_q;
  assign lfsr_reset  = lfsr_q;
  assign latched_reg = latched_q;

endmodule

// File: tb/tb_psg_register_interface.sv
// Bench for psg_register_interface: one instance with no write throttling
// (register decode, scoreboarded per accepted write) and one with 32-cycle throttling.
module tb_psg_register_interface;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  d0, d32;
  logic        wr0, wr32;

  logic        ready0, overrun0, lfsr0;
  logic [15:0] attn0;
  logic [29:0] tone0;
  logic [2:0]  noise0, lreg0;

  logic        ready32, overrun32, lfsr32;
  logic [15:0] attn32;
  logic [29:0] tone32;
  logic [2:0]  noise32, lreg32;

  psg_register_interface #(.WRITE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(d0), .wr_en(wr0),
    .ready(ready0), .overrun(overrun0), .attn_flat(attn0),
    .tone_freq_flat(tone0), .noise_ctrl(noise0),
    .lfsr_reset(lfsr0), .latched_reg(lreg0)
  );

  psg_register_interface #(.WRITE_CYCLES(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .data_in(d32), .wr_en(wr32),
    .ready(ready32), .overrun(overrun32), .attn_flat(attn32),
    .tone_freq_flat(tone32), .noise_ctrl(noise32),
    .lfsr_reset(lfsr32), .latched_reg(lreg32)
  );

  typedef struct packed {
    logic [15:0] attn;
    logic [29:0] tone;
    logic [2:0]  noise;
    logic [2:0]  lreg;
    logic        lfsr;
  } snap_t;

  snap_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic snap_t S(input logic [15:0] a, input logic [29:0] t,
                              input logic [2:0] n, input logic [2:0] l, input logic f);
    snap_t s;
    s.attn = a; s.tone = t; s.noise = n; s.lreg = l; s.lfsr = f;
    return s;
  endfunction

  // Single write on the unthrottled instance, then one idle cycle.
  task automatic wr0_byte(input logic [7:0] b, input snap_t e);
    @(negedge clk);
    d0 = b; wr0 = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    wr0 = 1'b0;
  endtask

  // Monitor: every accepted write on dut0 is compared one cycle later against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && wr0 && ready0) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_extra: accept with no expected entry, attn=%0h tone=%0h", attn0, tone0);
        end else begin
          snap_t e;
          e = exp_q.pop_front();
          chk("sb_attn",  32'(attn0),  32'(e.attn));
          chk("sb_tone",  32'(tone0),  32'(e.tone));
          chk("sb_noise", 32'(noise0), 32'(e.noise));
          chk("sb_lreg",  32'(lreg0),  32'(e.lreg));
          chk("sb_lfsr",  32'(lfsr0),  32'(e.lfsr));
        end
      end
    end
  end

  initial begin
    int low_cnt;
    int ovr_cnt;
    rst_n = 1'b0; d0 = '0; d32 = '0; wr0 = 1'b0; wr32 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_attn",    32'(attn0),    32'hFFFF);
    chk("rst_tone",    32'(tone0),    32'h0);
    chk("rst_noise",   32'(noise0),   32'h0);
    chk("rst_lreg",    32'(lreg0),    32'h0);
    chk("rst_lfsr",    32'(lfsr0),    32'h0);
    chk("rst_ready",   32'(ready0),   32'h1);
    chk("rst_overrun", 32'(overrun0), 32'h0);
    chk("rst_attn32",  32'(attn32),   32'hFFFF);
    chk("rst_ready32", 32'(ready32),  32'h1);

    // Unlatched data byte goes to tone 0 high bits.
    wr0_byte(8'h2A, S(16'hFFFF, 30'h000002A0, 3'h0, 3'h0, 1'b0));
    // Tone 0: latch low nibble, then high bits, then high bits again.
    wr0_byte(8'h8E, S(16'hFFFF, 30'h000002AE, 3'h0, 3'h0, 1'b0));
    wr0_byte(8'h0F, S(16'hFFFF, 30'h000000FE, 3'h0, 3'h0, 1'b0));
    wr0_byte(8'h03, S(16'hFFFF, 30'h0000003E, 3'h0, 3'h0, 1'b0));
    // Tone 2: latch low nibble 1, data 7F (bit 6 ignored) -> 3F1.
    wr0_byte(8'hC1, S(16'hFFFF, 30'h0010003E, 3'h0, 3'h4, 1'b0));
    wr0_byte(8'h7F, S(16'hFFFF, 30'h3F10003E, 3'h0, 3'h4, 1'b0));
    // Attenuation: D5 -> reg 101 (channel 2), B5 -> reg 011 (channel 1).
    wr0_byte(8'hD5, S(16'hF5FF, 30'h3F10003E, 3'h0, 3'h5, 1'b0));
    wr0_byte(8'hB5, S(16'hF55F, 30'h3F10003E, 3'h0, 3'h3, 1'b0));
    // Noise latch then data byte, each with a single lfsr_reset pulse.
    wr0_byte(8'hE6, S(16'hF55F, 30'h3F10003E, 3'h6, 3'h6, 1'b1));
    @(negedge clk);
    chk("lfsr_drop1", 32'(lfsr0), 32'h0);
    wr0_byte(8'h03, S(16'hF55F, 30'h3F10003E, 3'h3, 3'h6, 1'b1));
    @(negedge clk);
    chk("lfsr_drop2", 32'(lfsr0), 32'h0);
    // Back-to-back noise writes keep lfsr_reset high on consecutive cycles.
    @(negedge clk);
    d0 = 8'hE5; wr0 = 1'b1;
    exp_q.push_back(S(16'hF55F, 30'h3F10003E, 3'h5, 3'h6, 1'b1));
    @(negedge clk);
    d0 = 8'h02;
    exp_q.push_back(S(16'hF55F, 30'h3F10003E, 3'h2, 3'h6, 1'b1));
    @(negedge clk);
    wr0 = 1'b0;
    @(negedge clk);
    chk("lfsr_drop3", 32'(lfsr0), 32'h0);
    // Noise-channel attenuation via latch, then via data byte.
    wr0_byte(8'hF7, S(16'h755F, 30'h3F10003E, 3'h2, 3'h7, 1'b0));
    wr0_byte(8'h0C, S(16'hC55F, 30'h3F10003E, 3'h2, 3'h7, 1'b0));
    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    chk("overrun0_never", 32'(overrun0), 32'h0);

    // Throttled instance: hold 8'h91 (attn[0]=1) on wr_en continuously.
    @(negedge clk);
    d32 = 8'h91; wr32 = 1'b1;
    low_cnt = 0; ovr_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k <= 33 && !ready32) low_cnt++;
      if (overrun32) ovr_cnt++;
      if (k == 1) begin
        chk("hs_ready_low",   32'(ready32),   32'h0);
        chk("hs_overrun_first", 32'(overrun32), 32'h0);
        chk("hs_attn",        32'(attn32),    32'hFFF1);
        d32 = 8'h9A;
      end
      if (k == 32) begin
        chk("hs_dropped_unchanged", 32'(attn32), 32'hFFF1);
        d32 = 8'h91;
      end
      if (k == 33) chk("hs_ready_back", 32'(ready32), 32'h1);
      if (k == 34) begin
        chk("hs_reaccept", 32'(ready32), 32'h0);
        chk("hs_attn2",    32'(attn32),  32'hFFF1);
      end
    end
    wr32 = 1'b0;
    chk("hs_low_cycles",   32'(low_cnt), 32'd32);
    chk("hs_overrun_cnt",  32'(ovr_cnt), 32'd32);

    // Asynchronous reset while dut32 is busy, away from any clock edge.
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready32", 32'(ready32),   32'h1);
    chk("arst_attn32",  32'(attn32),    32'hFFFF);
    chk("arst_ovr32",   32'(overrun32), 32'h0);
    chk("arst_attn0",   32'(attn0),     32'hFFFF);
    chk("arst_tone0",   32'(tone0),     32'h0);
    chk("arst_noise0",  32'(noise0),    32'h0);
    chk("arst_lreg0",   32'(lreg0),     32'h0);

    // First rising edge after release accepts a write.
    @(negedge clk);
    rst_n = 1'b1; d32 = 8'h91; wr32 = 1'b1;
    @(negedge clk);
    chk("post_rst_accept", 32'(ready32), 32'h0);
    chk("post_rst_attn",   32'(attn32),  32'hFFF1);
    wr32 = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
